// File: rtl/encrypter_scheduler.sv
// encrypter_scheduler
//   Shares one encrypter between two requesters (A and B) with round-robin
//   arbitration, one word in flight at a time, and handles key programming.
//   Each issued word carries a rotation value that counts words since the
//   last key program (cleared by reset and by programming, wraps naturally).
//
// Ports
//   clk, reset                       clock (rising edge), async active-low reset
//   key_load, key_in, key_busy       key programming request / value / busy
//   req_valid_x, req_data_x,
//   req_ready_x (x = a, b)           requester word handshakes
//   res_valid, res_data, res_id,
//   res_ready                        result handshake (res_id: 0 = A, 1 = B)
//   enc_*                            encrypter-side handshake signals

`ifndef ENCRYPTER_WIDTH
`define ENCRYPTER_WIDTH 32
`endif
`ifndef KEY_ROTATION_WIDTH
`define KEY_ROTATION_WIDTH 5
`endif

module encrypter_scheduler #(
  parameter int unsigned ENC_W = `ENCRYPTER_WIDTH,
  parameter int unsigned ROT_W = `KEY_ROTATION_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_load,
  input  logic [ENC_W-1:0] key_in,
  output logic             key_busy,
  input  logic             req_valid_a,
  input  logic [ENC_W-1:0] req_data_a,
  output logic             req_ready_a,
  input  logic             req_valid_b,
  input  logic [ENC_W-1:0] req_data_b,
  output logic             req_ready_b,
  output logic             res_valid,
  output logic [ENC_W-1:0] res_data,
  output logic             res_id,
  input  logic             res_ready,
  output logic [ENC_W-1:0] enc_data_in,
  output logic [ROT_W-1:0] enc_key_rot,
  output logic             enc_prog,
  output logic             enc_data_ready_in,
  input  logic             enc_ready,
  input  logic [ENC_W-1:0] enc_data_out,
  input  logic             enc_data_ready_out,
  output logic             enc_capture
);

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    PROG_WAIT,
    ISSUE,
    WAIT_RES,
    DELIVER
  } state_t;

  state_t           state, state_nxt;
  logic [ENC_W-1:0] key_q;
  logic [ENC_W-1:0] word_q;
  logic [ENC_W-1:0] res_q;
  logic             id_q;
  logic             last_grant_q;
  logic             seen_low_q;
  logic [ROT_W-1:0] rot_q;

  logic             grant_en;
  logic             grant_sel;

  // Arbitration: with both requesters valid the one not granted last time
  // wins; otherwise the single valid requester wins.
  always_comb begin
    grant_sel = 1'b0;
    grant_en  = 1'b0;
    if (req_valid_a && req_valid_b) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req_valid_b;
    end
    grant_en = (state == IDLE) && !key_load && enc_ready &&
               (req_valid_a || req_valid_b);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (key_load) begin
          state_nxt = PROG;
        end else if (grant_en) begin
          state_nxt = ISSUE;
        end
      end
      PROG: begin
        if (enc_ready) begin
          state_nxt = PROG_WAIT;
        end
      end
      PROG_WAIT: begin
        if (seen_low_q && enc_ready) begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (!enc_ready) begin
          state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (enc_data_ready_out) begin
          state_nxt = DELIVER;
        end
      end
      DELIVER: begin
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from state and registers; reset forces IDLE so they all
  // fall to zero. The grant strobe depends on live inputs, so it is gated by
  // reset explicitly.
  always_comb begin
    req_ready_a       = reset && grant_en && !grant_sel;
    req_ready_b       = reset && grant_en && grant_sel;
    key_busy          = (state == PROG) || (state == PROG_WAIT);
    enc_prog          = (state == PROG) && enc_ready;
    enc_data_ready_in = (state == ISSUE);
    enc_capture       = (state == WAIT_RES) && enc_data_ready_out;
    res_valid         = (state == DELIVER);
    res_data          = res_q;
    res_id            = id_q;
    enc_data_in       = '0;
    enc_key_rot       = '0;
    if (state == PROG) begin
      enc_data_in = key_q;
    end else if (state == ISSUE) begin
      enc_data_in = word_q;
      enc_key_rot = rot_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      key_q        <= '0;
      word_q       <= '0;
      res_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      seen_low_q   <= 1'b0;
      rot_q        <= '0;
    end else begin
      state <= state_nxt;

      if ((state == IDLE) && key_load) begin
        key_q <= key_in;
      end

      if (grant_en) begin
        word_q       <= grant_sel ? req_data_b : req_data_a;
        id_q         <= grant_sel;
        last_grant_q <= grant_sel;
      end

      // Re-ready detection: the encrypter must be seen low before a high
      // level counts as programming complete.
      if (state == PROG) begin
        seen_low_q <= 1'b0;
      end else if ((state == PROG_WAIT) && !enc_ready) begin
        seen_low_q <= 1'b1;
      end

      if ((state == PROG) && enc_ready) begin
        rot_q <= '0;
      end else if ((state == ISSUE) && !enc_ready) begin
        rot_q <= rot_q + ROT_W'(1);
      end

      if ((state == WAIT_RES) && enc_data_ready_out) begin
        res_q <= enc_data_out;
      end
    end
  end

endmodule

// File: tb/tb_encrypter_scheduler.sv
module tb_encrypter_scheduler;

  logic        clk;
  logic        reset;
  logic        key_load;
  logic [31:0] key_in;
  logic        key_busy;
  logic        req_valid_a;
  logic [31:0] req_data_a;
  logic        req_ready_a;
  logic        req_valid_b;
  logic [31:0] req_data_b;
  logic        req_ready_b;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_ready;
  logic [31:0] enc_data_in;
  logic [4:0]  enc_key_rot;
  logic        enc_prog;
  logic        enc_data_ready_in;
  logic        enc_ready;
  logic [31:0] enc_data_out;
  logic        enc_data_ready_out;
  logic        enc_capture;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: who was granted last, words issued since the
  // last key program or reset.
  logic        m_last;
  int unsigned m_words;

  encrypter_scheduler #(.ENC_W(32), .ROT_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .key_load          (key_load),
    .key_in            (key_in),
    .key_busy          (key_busy),
    .req_valid_a       (req_valid_a),
    .req_data_a        (req_data_a),
    .req_ready_a       (req_ready_a),
    .req_valid_b       (req_valid_b),
    .req_data_b        (req_data_b),
    .req_ready_b       (req_ready_b),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .res_id            (res_id),
    .res_ready         (res_ready),
    .enc_data_in       (enc_data_in),
    .enc_key_rot       (enc_key_rot),
    .enc_prog          (enc_prog),
    .enc_data_ready_in (enc_data_ready_in),
    .enc_ready         (enc_ready),
    .enc_data_out      (enc_data_out),
    .enc_data_ready_out(enc_data_ready_out),
    .enc_capture       (enc_capture)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_key(input logic [31:0] k, input logic with_req, input int unsigned low_cycles);
    key_load    = 1'b1;
    key_in      = k;
    enc_ready   = 1'b1;
    req_valid_a = with_req;
    req_data_a  = $urandom;
    #1;
    chk1("prog_accept_busy", key_busy, 1'b0);
    chk1("prog_key_priority", req_ready_a, 1'b0);
    chk1("prog_accept_prog", enc_prog, 1'b0);
    tick();
    key_load    = 1'b0;
    req_valid_a = 1'b0;
    key_in      = ~k;
    #1;
    chk1("prog_busy", key_busy, 1'b1);
    chk1("prog_pulse", enc_prog, 1'b1);
    chk32("prog_data", enc_data_in, k);
    chk1("prog_no_issue", enc_data_ready_in, 1'b0);
    tick();
    #1;
    chk1("prog_pulse_end", enc_prog, 1'b0);
    chk1("prog_wait_busy", key_busy, 1'b1);
    tick();
    enc_ready = 1'b0;
    for (int unsigned i = 0; i < low_cycles; i++) begin
      #1;
      chk1("prog_low_busy", key_busy, 1'b1);
      chk1("prog_low_prog", enc_prog, 1'b0);
      tick();
    end
    enc_ready = 1'b1;
    #1;
    chk1("prog_reready_busy", key_busy, 1'b1);
    tick();
    #1;
    chk1("prog_done_busy", key_busy, 1'b0);
    m_words = 0;
  endtask

  task automatic run_word(input logic va, input logic vb,
                          input logic [31:0] da, input logic [31:0] db,
                          input logic [31:0] resp,
                          input int unsigned hold, input int unsigned lat,
                          input int unsigned stall, input logic key_poke);
    logic        g;
    logic [31:0] wexp;
    logic [31:0] rexp;
    g    = (va && vb) ? !m_last : !va;
    wexp = g ? db : da;
    rexp = 32'(m_words % 32);

    // Grant cycle
    req_valid_a        = va;
    req_valid_b        = vb;
    req_data_a         = da;
    req_data_b         = db;
    enc_ready          = 1'b1;
    res_ready          = 1'b0;
    enc_data_ready_out = 1'b0;
    #1;
    chk1("grant_a", req_ready_a, !g);
    chk1("grant_b", req_ready_b, g);
    chk1("grant_no_issue", enc_data_ready_in, 1'b0);
    tick();

    // Issue: held while encrypter stays ready
    for (int unsigned i = 0; i <= hold; i++) begin
      if (i == hold) enc_ready = 1'b0;
      #1;
      chk1("issue_valid", enc_data_ready_in, 1'b1);
      chk32("issue_data", enc_data_in, wexp);
      chk32("issue_rot", 32'(enc_key_rot), rexp);
      chk1("issue_no_prog", enc_prog, 1'b0);
      chk1("issue_no_grant_a", req_ready_a, 1'b0);
      chk1("issue_no_grant_b", req_ready_b, 1'b0);
      tick();
    end

    // Waiting for the result; an out-of-IDLE key_load must be ignored
    key_load = key_poke;
    key_in   = ~da;
    for (int unsigned i = 0; i < lat; i++) begin
      #1;
      chk1("wait_issue_off", enc_data_ready_in, 1'b0);
      chk1("wait_no_capture", enc_capture, 1'b0);
      chk1("wait_no_res", res_valid, 1'b0);
      chk1("wait_no_grant", req_ready_a | req_ready_b, 1'b0);
      chk1("wait_key_ignored", key_busy, 1'b0);
      tick();
    end
    enc_data_ready_out = 1'b1;
    enc_data_out       = resp;
    #1;
    chk1("capture_pulse", enc_capture, 1'b1);
    chk1("capture_no_res", res_valid, 1'b0);
    tick();

    // Deliver
    enc_data_ready_out = 1'b0;
    enc_data_out       = $urandom;
    enc_ready          = 1'b1;
    key_load           = 1'b0;
    for (int unsigned i = 0; i < stall; i++) begin
      #1;
      chk1("stall_valid", res_valid, 1'b1);
      chk32("stall_data", res_data, resp);
      chk1("stall_id", res_id, g);
      chk1("stall_no_capture", enc_capture, 1'b0);
      chk1("stall_no_grant", req_ready_a | req_ready_b, 1'b0);
      chk1("stall_no_issue", enc_data_ready_in, 1'b0);
      chk1("stall_key_ignored", key_busy, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk1("res_valid", res_valid, 1'b1);
    chk32("res_data", res_data, resp);
    chk1("res_id", res_id, g);
    chk1("res_no_grant", req_ready_a | req_ready_b, 1'b0);
    tick();
    res_ready   = 1'b0;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    #1;
    chk1("res_done", res_valid, 1'b0);
    m_last = g;
    m_words++;
  endtask

  initial begin
    int unsigned pick;
    logic [31:0] tmp;

    reset              = 1'b0;
    key_load           = 1'b0;
    key_in             = '0;
    req_valid_a        = 1'b1;
    req_valid_b        = 1'b1;
    req_data_a         = 32'h1234_5678;
    req_data_b         = 32'h9ABC_DEF0;
    res_ready          = 1'b0;
    enc_ready          = 1'b1;
    enc_data_out       = 32'hFFFF_FFFF;
    enc_data_ready_out = 1'b1;
    m_last             = 1'b1;
    m_words            = 0;

    // Reset state
    #1;
    chk1("rst_req_ready_a", req_ready_a, 1'b0);
    chk1("rst_req_ready_b", req_ready_b, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk32("rst_res_data", res_data, 32'h0);
    chk1("rst_res_id", res_id, 1'b0);
    chk32("rst_enc_data_in", enc_data_in, 32'h0);
    chk32("rst_enc_key_rot", 32'(enc_key_rot), 32'h0);
    chk1("rst_enc_prog", enc_prog, 1'b0);
    chk1("rst_enc_data_ready_in", enc_data_ready_in, 1'b0);
    chk1("rst_enc_capture", enc_capture, 1'b0);
    chk1("rst_key_busy", key_busy, 1'b0);
    req_valid_a        = 1'b0;
    req_valid_b        = 1'b0;
    enc_data_ready_out = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Key program with a competing request in the same cycle
    prog_key(32'hB4352B93, 1'b1, 2);

    // Contention: both requesters always valid
    for (int k = 0; k < 4; k++) begin
      run_word(1'b1, 1'b1, $urandom, $urandom, $urandom,
               $urandom_range(0, 2), $urandom_range(1, 3), 0, k == 1);
    end

    // Single word from A with a fixed response
    prog_key($urandom, 1'b0, 1);
    run_word(1'b1, 1'b0, 32'h1F537C8A, $urandom, 32'hDEADBEEF, 0, 1, 0, 1'b0);

    // Rotation wrap over 33 words with random requester patterns
    prog_key($urandom, 1'b0, 3);
    for (int k = 0; k < 33; k++) begin
      pick = $urandom_range(1, 3);
      run_word((pick & 1) != 0, (pick & 2) != 0, $urandom, $urandom, $urandom,
               $urandom_range(0, 1), $urandom_range(1, 2), $urandom_range(0, 1), 1'b0);
    end

    // Result backpressure
    run_word(1'b1, 1'b1, $urandom, $urandom, $urandom, 1, 2, 5, 1'b0);

    // Reset while waiting for the encrypter result
    tmp         = $urandom;
    req_valid_a = 1'b1;
    req_valid_b = 1'b0;
    req_data_a  = tmp;
    enc_ready   = 1'b1;
    #1;
    chk1("pre_rst_grant", req_ready_a, 1'b1);
    tick();
    enc_ready = 1'b0;
    #1;
    chk32("pre_rst_issue", enc_data_in, tmp);
    tick();
    #1;
    chk1("pre_rst_waiting", enc_data_ready_in, 1'b0);
    req_valid_b        = 1'b1;
    enc_ready          = 1'b1;
    enc_data_ready_out = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk1("mid_rst_req_ready_a", req_ready_a, 1'b0);
    chk1("mid_rst_req_ready_b", req_ready_b, 1'b0);
    chk1("mid_rst_res_valid", res_valid, 1'b0);
    chk32("mid_rst_res_data", res_data, 32'h0);
    chk1("mid_rst_res_id", res_id, 1'b0);
    chk32("mid_rst_enc_data_in", enc_data_in, 32'h0);
    chk32("mid_rst_enc_key_rot", 32'(enc_key_rot), 32'h0);
    chk1("mid_rst_enc_prog", enc_prog, 1'b0);
    chk1("mid_rst_enc_data_ready_in", enc_data_ready_in, 1'b0);
    chk1("mid_rst_enc_capture", enc_capture, 1'b0);
    chk1("mid_rst_key_busy", key_busy, 1'b0);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    @(posedge clk);
    #2;
    reset   = 1'b1;
    m_last  = 1'b1;
    m_words = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk1("post_rst_no_res", res_valid, 1'b0);
      chk1("post_rst_no_capture", enc_capture, 1'b0);
      enc_data_ready_out = 1'b0;
    end

    // First word after reset: A wins, rotation restarts at 0
    run_word(1'b1, 1'b1, $urandom, $urandom, $urandom, 0, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
